// File: rtl/uart_rx_vote_sampler.sv
// uart_rx_vote_sampler: majority-vote UART bit sampler over an odd window centred on the bit mid-point.
module uart_rx_vote_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int NSAMP       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  RX_IN,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err,
  output logic                  cfg_err
);
  localparam int W = PRESCALE_W + 1;
  localparam int H = (NSAMP - 1) / 2;
  logic rx_s;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge CLK or negedge RST)
        if (!RST) sync_q <= '1;
        else      sync_q <= SYNC_STAGES'({sync_q, RX_IN});
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate
  logic [W-1:0] mid, first, last, decide, ec, pm1, slot;
  assign mid    = {1'b0, Prescale} >> 1;
  assign first  = mid - W'(H);
  assign last   = mid + W'(H);
  assign decide = last + W'(1);
  assign ec     = {1'b0, edge_cnt};
  assign pm1    = {1'b0, Prescale} - W'(1);
  assign slot   = ec - first;
  logic in_win, cfg_d, cfg_q;
  assign in_win = (ec >= first) && (ec <= last);
  assign cfg_d  = Prescale[0] | (mid < W'(H)) | (decide > pm1) | ({1'b0, Prescale} < W'(4));
  logic [NSAMP-1:0] votes_q, votes_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       pc;
  logic             bit_q, bit_d, noise_q, noise_d, valid_q, valid_d;
  always_comb begin
    votes_d = votes_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    noise_d = noise_q;
    valid_d = 1'b0;
    pc      = '0;
    for (int k = 0; k < NSAMP; k++) pc = pc + 4'(votes_q[k]);
    if (!dat_samp_en) begin
      votes_d = '0;
      cnt_d   = '0;
    end else if (!cfg_q && in_win) begin
      for (int k = 0; k < NSAMP; k++) votes_d[k] = (slot == W'(k)) ? rx_s : votes_q[k];
      cnt_d = cnt_q + 8'd1;
    end else if (!cfg_q && ec == decide) begin
      // A disturbed window (count mismatch) drops the bit silently
      cnt_d = '0;
      if (cnt_q == 8'(NSAMP)) begin
        valid_d = 1'b1;
        bit_d   = pc > 4'(H);
        noise_d = (pc != 4'd0) && (pc != 4'(NSAMP));
      end
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      votes_q <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      noise_q <= 1'b0;
      valid_q <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      votes_q <= votes_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      noise_q <= noise_d;
      valid_q <= valid_d;
      cfg_q   <= cfg_d;
    end
  assign sampled_bit  = bit_q;
  assign sample_valid = valid_q;
  assign noise_err    = noise_q;
  assign cfg_err      = cfg_q;
endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// tb_uart_rx_vote_sampler: two configurations (3 votes/no sync, 5 votes/2-stage sync) against a behavioural model.
module tb_uart_rx_vote_sampler;
  logic CLK = 1'b0, RST = 1'b0;
  logic [5:0] P = 6'd8, ec = '0;
  logic en = 1'b0, rx = 1'b1;
  logic [1:0] sb, sv, nz, ce;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  uart_rx_vote_sampler #(.PRESCALE_W(6), .NSAMP(3), .SYNC_STAGES(0)) u0 (
    .CLK(CLK), .RST(RST), .Prescale(P), .dat_samp_en(en), .edge_cnt(ec), .RX_IN(rx),
    .sampled_bit(sb[0]), .sample_valid(sv[0]), .noise_err(nz[0]), .cfg_err(ce[0]));
  uart_rx_vote_sampler #(.PRESCALE_W(6), .NSAMP(5), .SYNC_STAGES(2)) u1 (
    .CLK(CLK), .RST(RST), .Prescale(P), .dat_samp_en(en), .edge_cnt(ec), .RX_IN(rx),
    .sampled_bit(sb[1]), .sample_valid(sv[1]), .noise_err(nz[1]), .cfg_err(ce[1]));
  typedef struct { logic [7:0] v; int cnt; logic b, val, nz, cfg; } mst_t;
  function automatic mst_t zero_st();
    mst_t r;
    r.v = '0; r.cnt = 0; r.b = 0; r.val = 0; r.nz = 0; r.cfg = 0;
    return r;
  endfunction
  // One bit-time rule set: window from current Prescale, gated by last cycle's config verdict
  function automatic mst_t nxt(mst_t s, int n, int p, logic e, int c, logic r);
    mst_t o = s;
    int h = (n - 1) / 2, mid = p / 2;
    int first = (mid - h) & 127, last = (mid + h) & 127, dec = (mid + h + 1) & 127, pc = 0;
    o.val = 0;
    o.cfg = (p % 2 == 1) || (mid < h) || (dec > p - 1) || (p < 4);
    if (!e) begin
      o.cnt = 0; o.v = '0;
    end else if (!s.cfg) begin
      if (c >= first && c <= last) begin
        o.v[c - first] = r; o.cnt = s.cnt + 1;
      end else if (c == dec) begin
        if (s.cnt == n) begin
          for (int k = 0; k < n; k++) pc += int'(s.v[k]);
          o.b = pc > h; o.nz = (pc != 0) && (pc != n); o.val = 1;
        end
        o.cnt = 0;
      end
    end
    return o;
  endfunction
  mst_t m [2];
  logic h1, h2;
  always @(posedge CLK or negedge RST)
    if (!RST) begin
      m[0] <= zero_st(); m[1] <= zero_st(); h1 <= 1'b1; h2 <= 1'b1;
    end else begin
      m[0] <= nxt(m[0], 3, int'(P), en, int'(ec), rx);
      m[1] <= nxt(m[1], 5, int'(P), en, int'(ec), h2);
      h1 <= rx; h2 <= h1;
    end
  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, e);
    end
  endtask
  always @(negedge CLK)
    if (RST)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_valid%0d", i), sv[i], m[i].val);
        chk($sformatf("model_bit%0d", i), sb[i], m[i].b);
        chk($sformatf("model_noise%0d", i), nz[i], m[i].nz);
        chk($sformatf("model_cfg%0d", i), ce[i], m[i].cfg);
      end
  task automatic step(input logic e, input int c, input logic r);
    en = e; ec = 6'(c); rx = r;
    @(posedge CLK); #1;
  endtask
  // c*=1: expect strobe with b*/n*; c*=2: expect no strobe and held bit b*
  task automatic sweep(input int p, input logic [63:0] zeros, input int drop,
                       input int c0, input logic b0, input logic n0,
                       input int c1, input logic b1, input logic n1);
    P = 6'(p);
    for (int e = 0; e < p; e++) begin
      step(e != drop, e, !zeros[e]);
      if (e == p / 2 + 2 && c0 == 1) begin
        chk("u0_valid", sv[0], 1); chk("u0_bit", sb[0], b0); chk("u0_noise", nz[0], n0);
      end
      if (e == p / 2 + 2 && c0 == 2) begin
        chk("u0_nostrobe", sv[0], 0); chk("u0_hold", sb[0], b0);
      end
      if (e == p / 2 + 3 && c1 == 1) begin
        chk("u1_valid", sv[1], 1); chk("u1_bit", sb[1], b1); chk("u1_noise", nz[1], n1);
      end
      if (e == p / 2 + 3 && c1 == 2) begin
        chk("u1_nostrobe", sv[1], 0); chk("u1_hold", sb[1], b1);
      end
    end
  endtask
  int plist [9] = '{8, 10, 12, 16, 20, 62, 6, 7, 4};
  initial begin
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_bit", sb[i], 0); chk("rst_valid", sv[i], 0);
      chk("rst_noise", nz[i], 0); chk("rst_cfg", ce[i], 0);
    end
    #10 RST = 1'b1;
    repeat (3) step(0, 0, 1);
    sweep(8, 64'h0, -1, 1, 1, 0, 1, 1, 0);
    sweep(8, 64'h10, -1, 1, 1, 1, 1, 1, 1);
    sweep(8, 64'h18, -1, 1, 0, 1, 1, 1, 1);
    sweep(16, 64'h110, -1, 1, 1, 1, 1, 1, 1);
    sweep(8, 64'h0, 4, 2, 1, 0, 2, 1, 0);
    P = 6'd7; step(1, 0, 1);
    chk("cfg_p7_u0", ce[0], 1); chk("cfg_p7_u1", ce[1], 1);
    sweep(7, 64'h0, -1, 2, 1, 0, 2, 1, 0);
    P = 6'd2; step(1, 0, 1); step(1, 1, 1);
    chk("cfg_p2_u0", ce[0], 1); chk("cfg_p2_u1", ce[1], 1);
    P = 6'd8; step(0, 0, 1);
    chk("cfg_p8_u0", ce[0], 0); chk("cfg_p8_u1", ce[1], 0);
    P = 6'd8;
    for (int e = 0; e < 5; e++) step(1, e, 1);
    #2 RST = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_bit", sb[i], 0); chk("arst_valid", sv[i], 0);
      chk("arst_noise", nz[i], 0); chk("arst_cfg", ce[i], 0);
    end
    en = 1'b0; rx = 1'b1; ec = '0;
    #3 RST = 1'b1;
    repeat (2) step(0, 0, 1);
    sweep(8, 64'h0, -1, 1, 1, 0, 1, 1, 0);
    for (int b = 0; b < 150; b++) begin
      int p;
      logic base;
      p = plist[$urandom_range(8, 0)];
      base = 1'($urandom);
      P = 6'(p);
      for (int e = 0; e < p; e++) begin
        if (e == p / 2 && $urandom_range(9, 0) == 0) P = 6'(plist[$urandom_range(8, 0)]);
        step($urandom_range(24, 0) != 0,
             ($urandom_range(11, 0) == 0) ? int'($urandom_range(p - 1, 0)) : e,
             ($urandom_range(3, 0) == 0) ? !base : base);
      end
    end
    step(0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_vote_sampler.md
Name: uart_rx_vote_sampler

Overview:
Parametrised UART receive-side bit sampler. It oversamples RX_IN across a configurable window of odd length centred on the bit's mid-point and resolves the bit by majority vote. It emits a one-cycle valid strobe and a noise flag for every bit, and rejects illegal prescale settings. It sits between the RX edge/bit counter (which supplies edge_cnt) and the RX FSM / deserializer.

Parameters:
PRESCALE_W, 6, width of Prescale and edge_cnt.
NSAMP, 3, number of votes per bit; legal values are odd, 1..7.
SYNC_STAGES, 2, input synchroniser flops on RX_IN; legal range 0..3; 0 bypasses the synchroniser.

Ports:
CLK  input  1  oversampling clock.
RST  input  1  asynchronous, active-low reset.
Prescale  input  PRESCALE_W  oversampling ratio (edges per bit).
dat_samp_en  input  1  sampling enable from the RX FSM.
edge_cnt  input  PRESCALE_W  edge index within the current bit, 0..Prescale-1.
RX_IN  input  1  serial line; asynchronous when SYNC_STAGES>0.
sampled_bit  output  1  voted bit value.
sample_valid  output  1  one-cycle strobe; sampled_bit and noise_err are new this cycle.
noise_err  output  1  votes were not unanimous for this bit (valid with sample_valid).
cfg_err  output  1  Prescale is illegal for NSAMP.

Behaviour:
- Reset (RST=0, asynchronous): sampled_bit=0, sample_valid=0, noise_err=0, cfg_err=0, synchroniser flops=1 (line idle), vote store=0, capture count=0.
- Synchroniser: rx_s is RX_IN delayed by SYNC_STAGES CLK cycles. The edge_cnt alignment that compensates for this delay is the caller's job.
- Window arithmetic, in PRESCALE_W+1 bits:
  - mid = Prescale>>1, H = (NSAMP-1)/2.
  - first = mid-H, last = mid+H, decide = last+1.
- cfg_err (registered, updated every cycle) is set when any of these holds:
  - Prescale[0]=1;
  - mid<H;
  - decide>Prescale-1;
  - Prescale<4.
- While cfg_err=1: no captures occur and no sample_valid is issued.
- Capture: when dat_samp_en=1 and first<=edge_cnt<=last, rx_s at that cycle is stored in vote slot (edge_cnt-first), and the capture count increments by 1.
- Decision: when dat_samp_en=1, edge_cnt==decide, and capture count==NSAMP, on the next CLK edge:
  - sampled_bit <= 1 if popcount(votes) > H, else 0;
  - noise_err <= 1 if popcount is neither 0 nor NSAMP;
  - sample_valid <= 1 for exactly one cycle;
  - capture count clears to 0.
- Latency: sample_valid asserts one cycle after the edge_cnt==decide cycle.
- If edge_cnt==decide but capture count!=NSAMP (window disturbed): no strobe, noise_err is unchanged, and capture count clears.
- dat_samp_en=0 on any cycle: capture count and vote store clear, sample_valid=0, sampled_bit and noise_err hold their last values. Dropping the enable mid-window aborts that bit silently.
- edge_cnt outside [first, decide]: no action on the vote store.
- An edge_cnt value repeated inside the window overwrites its slot. The count still increments, so the count no longer matches the slot coverage, and the decision is suppressed unless the count equals NSAMP exactly.
- NSAMP=1: a single capture at mid, decide=mid+1, and noise_err is always 0.
- A Prescale change while dat_samp_en=1 takes effect on the next cycle. The in-flight bit produces a strobe only if the count and decide conditions are met under the new window.
- Back-to-back bits: the capture count clears at decide, so the next bit starts clean when edge_cnt wraps to 0.

Test Plan:
1. Prescale=8, NSAMP=3, SYNC_STAGES=0, RX_IN=1 held, edge_cnt sweeping 0..7 with enable=1 → captures at edges 3, 4, 5; sample_valid high only in the cycle after edge 6; sampled_bit=1; noise_err=0.
2. Same setup, RX_IN=1,0,1 at edges 3, 4, 5 → sampled_bit=1, noise_err=1; with RX_IN=0,0,1 → sampled_bit=0, noise_err=1.
3. NSAMP=5, Prescale=16, 0 forced at edges 6 and 10 with 1 elsewhere → votes 0,1,1,1,0; sampled_bit=1; noise_err=1; strobe after edge 11.
4. Drop dat_samp_en at edge 4, re-raise it at edge 5, Prescale=8 → no sample_valid for that bit; sampled_bit keeps its previous value.
5. Prescale=7, then Prescale=2, NSAMP=3 → cfg_err=1 in both cases and no strobes; Prescale=8 → cfg_err=0 one cycle later.
6. SYNC_STAGES=2, RX_IN stepping 1→0 and edge_cnt offset by +2 → same votes as scenario 1; async RST asserted mid-window → all outputs 0 immediately, and the next full bit after release resolves correctly.
